// File: rtl/instr_issue_queue.sv
// -----------------------------------------------------------------------------
// instr_issue_queue
//
// Instruction source for the 4-stage 8-bit core. A loader pushes 8-bit
// instructions into a DEPTH-entry FIFO. While run is high, the queue issues at
// most one instruction per clock on a registered output.
//
// When the queue is empty, halted (run low) or flushed, a NOP bubble is issued
// with instr_valid low. As a result, the core never sees an undefined or
// repeated instruction.
//
// Optional feature: define ISSUE_CNT_EN to add the 16-bit issued_cnt counter.
// The counter counts pops, wraps at 2^16, and is cleared only by reset.
//
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   in_valid     loader presents in_instr
//   in_instr     instruction {opcode[7:6], op1[5:3], op2[2:0]}
//   in_ready     queue can accept a word (= !full)
//   run          issue enable
//   flush        synchronous clear of queue and issue register
//   instr        registered instruction to the core (NOP when bubble)
//   instr_valid  instr is a real instruction
//   count        entries held, 0..DEPTH
//   empty, full  occupancy flags from registered state
//   issued_cnt   pop counter (only with ISSUE_CNT_EN)
// -----------------------------------------------------------------------------
module instr_issue_queue #(
    parameter int          DEPTH  = 8,
    parameter int          ADDR_W = 3,
    parameter logic [7:0]  NOP    = 8'hC0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_instr,
    output logic              in_ready,
    input  logic              run,
    input  logic              flush,
    output logic [7:0]        instr,
    output logic              instr_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
`ifdef ISSUE_CNT_EN
    ,
    output logic [15:0]       issued_cnt
`endif
);

    // Storage is deliberately not reset; only the pointers define what is valid.
    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              push, pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (ADDR_W+1)'(DEPTH));
    // Full blocks writes even when a pop happens in the same cycle (no pass-through).
    assign in_ready = !full;

    // Flush overrides both the push and the pop for that cycle.
    assign push = in_valid & in_ready & !flush;
    assign pop  = run & !empty & !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instr_d       = NOP;
        instr_valid_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // The pointers wrap naturally because DEPTH == 2**ADDR_W.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d      = rd_ptr_q + 1'b1;
                instr_d       = mem[rd_ptr_q];
                instr_valid_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign count       = count_q;

`ifdef ISSUE_CNT_EN
    logic [15:0] issued_cnt_q, issued_cnt_d;

    // Flush does not clear this counter; only reset does.
    always_comb begin
        issued_cnt_d = issued_cnt_q + 16'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) issued_cnt_q <= '0;
        else        issued_cnt_q <= issued_cnt_d;
    end

    assign issued_cnt = issued_cnt_q;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_queue
//
// Self-checking bench for instr_issue_queue. The reference model is a plain
// queue of bytes that follows the FIFO/issue rules. After each clock edge, the
// model is compared against the observable output vector
// {instr, instr_valid, count, empty, full, in_ready}.
// -----------------------------------------------------------------------------
module tb_instr_issue_queue;

    localparam logic [7:0] NOP = 8'hC0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_instr;
    logic        in_ready;
    logic        run;
    logic        flush;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [3:0]  count;
    logic        empty;
    logic        full;
`ifdef ISSUE_CNT_EN
    logic [15:0] issued_cnt;
`endif

    instr_issue_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .run         (run),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .count       (count),
        .empty       (empty),
        .full        (full)
`ifdef ISSUE_CNT_EN
        ,
        .issued_cnt  (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    logic [7:0] exp_instr;
    logic       exp_valid;
    int         exp_issued;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    wire [15:0] obs_vec = {instr, instr_valid, count, empty, full, in_ready};

    function automatic logic [15:0] exp_vec();
        int n = q.size();
        return {exp_instr, exp_valid, 4'(n), n == 0, n == 8, n != 8};
    endfunction

    task automatic model_reset();
        q.delete();
        exp_instr  = NOP;
        exp_valid  = 1'b0;
        exp_issued = 0;
    endtask

    // Applies one clock edge using the pre-edge occupancy of the model.
    task automatic model_edge(input logic v, input logic [7:0] d,
                              input logic r, input logic f);
        bit was_full;
        was_full = (q.size() == 8);
        if (f) begin
            q.delete();
            exp_instr = NOP;
            exp_valid = 1'b0;
        end else begin
            if (r && q.size() != 0) begin
                exp_instr = q.pop_front();
                exp_valid = 1'b1;
                exp_issued = (exp_issued + 1) % 65536;
            end else begin
                exp_instr = NOP;
                exp_valid = 1'b0;
            end
            if (v && !was_full) q.push_back(d);
        end
    endtask

    // Drive the inputs, take one rising edge, advance the model, then let the
    // outputs settle before any comparison.
    task automatic step(input logic v, input logic [7:0] d,
                        input logic r, input logic f);
        in_valid = v; in_instr = d; run = r; flush = f;
        @(posedge clk);
        model_edge(v, d, r, f);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 8'h00; run = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (obs_vec !== exp_vec())
            $display("FAIL reset_hold: got %h want %h", obs_vec, exp_vec());
        else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total_cnt++;
            if (obs_vec !== {NOP, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1})
                $display("FAIL reset_idle cyc%0d: got %h want %h", i, obs_vec,
                         {NOP, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1});
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        logic [7:0] seen [3];
        step(1'b1, 8'h8D, 1'b1, 1'b0);   // edge N: word written, no bypass
        seen[0] = instr;
        total_cnt++;
        if (obs_vec !== exp_vec() || instr_valid !== 1'b0)
            $display("FAIL single_push: got %h want %h", obs_vec, exp_vec());
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b1, 1'b0);   // edge N+1: issued
        seen[1] = instr;
        total_cnt++;
        if (instr !== 8'h8D || instr_valid !== 1'b1 || obs_vec !== exp_vec())
            $display("FAIL single_issue: got %h want %h", obs_vec, exp_vec());
        else pass_cnt++;
        step(1'b0, 8'h00, 1'b1, 1'b0);   // edge N+2: bubble, not a repeat
        seen[2] = instr;
        total_cnt++;
        if (instr !== NOP || instr_valid !== 1'b0 || obs_vec !== exp_vec())
            $display("FAIL single_bubble: got %h want %h (seen %h %h %h)",
                     obs_vec, exp_vec(), seen[0], seen[1], seen[2]);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            total_cnt++;
            if (obs_vec !== exp_vec())
                $display("FAIL fill push%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
        total_cnt++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4'd8)
            $display("FAIL fill_full: got full=%b rdy=%b cnt=%0d want 1 0 8",
                     full, in_ready, count);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total_cnt++;
            if (obs_vec !== exp_vec())
                $display("FAIL fill drain%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_steady();
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 1'b1, 1'b0);
            total_cnt++;
            if (obs_vec !== exp_vec() || count !== 4'd3)
                $display("FAIL steady cyc%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'h3A, 1'b1, 1'b1);
        total_cnt++;
        if (count !== 4'd0 || instr !== NOP || obs_vec !== exp_vec())
            $display("FAIL flush: got %h want %h", obs_vec, exp_vec());
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total_cnt++;
            if (obs_vec !== exp_vec())
                $display("FAIL flush_after cyc%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 8'($urandom),
                 $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 4);
            total_cnt++;
            if (obs_vec !== exp_vec())
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), (i == 3), 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total_cnt++;
        if (obs_vec !== exp_vec())
            $display("FAIL async_reset: got %h want %h", obs_vec, exp_vec());
        else pass_cnt++;
`ifdef ISSUE_CNT_EN
        total_cnt++;
        if (issued_cnt !== 16'd0)
            $display("FAIL reset_issued_cnt: got %0d want 0", issued_cnt);
        else pass_cnt++;
`endif
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total_cnt++;
            if (obs_vec !== exp_vec())
                $display("FAIL post_reset cyc%0d: got %h want %h", i, obs_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

`ifdef ISSUE_CNT_EN
    task automatic test_issue_cnt();
        int before;
        total_cnt++;
        if (issued_cnt !== 16'(exp_issued))
            $display("FAIL issued_cnt: got %0d want %0d", issued_cnt, exp_issued);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        before = exp_issued;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        total_cnt++;
        if (issued_cnt !== 16'(before))
            $display("FAIL issued_cnt_flush: got %0d want %0d", issued_cnt, before);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_steady();
        test_flush();
        test_random();
`ifdef ISSUE_CNT_EN
        test_issue_cnt();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
